// File: rtl/fpga_ram_arbiter.sv
// Two-master arbiter for the single-port fpga_ram (4096 x 32), three cycles per access.
// Define FPGA_RAM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module fpga_ram_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_cs,
  input  logic [3:0]  a_we,
  input  logic [11:0] a_address,
  input  logic [31:0] a_write_data,
  output logic [31:0] a_read_data,
  output logic        a_ready,
  input  logic        b_cs,
  input  logic [3:0]  b_we,
  input  logic [11:0] b_address,
  input  logic [31:0] b_write_data,
  output logic [31:0] b_read_data,
  output logic        b_ready,
  output logic        ram_cs,
  output logic [3:0]  ram_we,
  output logic [11:0] ram_address,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  logic   grant_b;
  logic   pick_b;

  // grant_b doubles as the round-robin history: it always names the last port served.
  always_comb begin
`ifdef FPGA_RAM_ARB_RR_EN
    if (a_cs && b_cs)
      pick_b = ~grant_b;
    else
      pick_b = b_cs;
`else
    pick_b = b_cs & ~a_cs;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant_b        <= 1'b0;
      a_read_data    <= '0;
      b_read_data    <= '0;
      a_ready        <= 1'b0;
      b_ready        <= 1'b0;
      ram_cs         <= 1'b0;
      ram_we         <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_ready <= 1'b0;
          b_ready <= 1'b0;
          if (a_cs || b_cs) begin
            ram_cs         <= 1'b1;
            ram_we         <= pick_b ? b_we : a_we;
            ram_address    <= pick_b ? b_address : a_address;
            ram_write_data <= pick_b ? b_write_data : a_write_data;
            grant_b        <= pick_b;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data is captured for writes too (old contents, write commits on this edge).
          if (grant_b) begin
            b_read_data <= ram_read_data;
            b_ready     <= 1'b1;
          end else begin
            a_read_data <= ram_read_data;
            a_ready     <= 1'b1;
          end
          ram_cs <= 1'b0;
          ram_we <= '0;
          state  <= DONE;
        end
        DONE: begin
          a_ready <= 1'b0;
          b_ready <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ram_cs <= 1'b0;
          ram_we <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_ram_arbiter.sv
// Randomized self-checking bench for fpga_ram_arbiter with a behavioural RAM and a
// transaction-level memory model; honours FPGA_RAM_ARB_RR_EN for expected grant order.
module tb_fpga_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_cs, b_cs;
  logic [3:0]  a_we, b_we;
  logic [11:0] a_address, b_address;
  logic [31:0] a_write_data, b_write_data;
  logic [31:0] a_read_data, b_read_data;
  logic        a_ready, b_ready;
  logic        ram_cs;
  logic [3:0]  ram_we;
  logic [11:0] ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  bit          ref_valid [4096];

  bit served_port[$];
  int served_cyc[$];

  logic [11:0] pool [8] = '{12'h000, 12'hFFF, 12'h010, 12'h555, 12'h123, 12'h800, 12'h7FF, 12'hABC};
  logic [31:0] rd_a, rd_b, rd;

  fpga_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_cs(a_cs), .a_we(a_we), .a_address(a_address), .a_write_data(a_write_data),
    .a_read_data(a_read_data), .a_ready(a_ready),
    .b_cs(b_cs), .b_we(b_we), .b_address(b_address), .b_write_data(b_write_data),
    .b_read_data(b_read_data), .b_ready(b_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM: combinational read, byte-enabled write on the clock edge.
  assign ram_read_data = mem[ram_address];
  always @(posedge clk)
    if (ram_cs && ram_we != 4'h0)
      mem[ram_address] <= merge(mem[ram_address], ram_write_data, ram_we);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mon_en) begin
      if (!ram_cs) check("we_while_idle", {28'b0, ram_we}, 32'h0);
      check("ready_exclusive", {31'b0, a_ready & b_ready}, 32'h0);
    end

  // One complete transaction on port A (pb=0) or B (pb=1); exp_lat<=0 skips the latency check.
  task automatic xact(input bit pb, input logic [3:0] we, input logic [11:0] addr,
                      input logic [31:0] wd, input int exp_lat, input int gap,
                      output logic [31:0] rd_out);
    int lat;
    bit ok;
    logic [31:0] got;
    if (pb) begin
      b_cs = 1'b1; b_we = we; b_address = addr; b_write_data = wd;
    end else begin
      a_cs = 1'b1; a_we = we; a_address = addr; a_write_data = wd;
    end
    lat = 0;
    ok = 1'b0;
    while (lat < 60 && !ok) begin
      @(posedge clk); #1;
      lat++;
      ok = pb ? b_ready : a_ready;
    end
    rd_out = 32'h0;
    check("ready_seen", {31'b0, ok}, 32'h1);
    if (ok) begin
      got = pb ? b_read_data : a_read_data;
      rd_out = got;
      served_port.push_back(pb);
      served_cyc.push_back(cyc);
      if (ref_valid[addr]) check(pb ? "b_read_data" : "a_read_data", got, ref_mem[addr]);
      ref_mem[addr] = merge(ref_mem[addr], wd, we);
      if (we == 4'hF) ref_valid[addr] = 1'b1;
      if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
      $display("xact port=%s we=%h addr=%h wd=%h rd=%h lat=%0d", pb ? "B" : "A", we, addr, wd, got, lat);
    end
    if (pb) begin b_cs = 1'b0; b_we = 4'h0; end
    else    begin a_cs = 1'b0; a_we = 4'h0; end
    if (ok) begin
      @(posedge clk); #1;
      check("ready_one_cycle", {31'b0, pb ? b_ready : a_ready}, 32'h0);
    end
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic rand_driver(input bit pb, input int n);
    logic [3:0]  we;
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) begin
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      xact(pb, we, pool[$urandom_range(0, 7)], $urandom, 0, $urandom_range(0, 3), dummy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_cs = 0; a_we = 0; a_address = 0; a_write_data = 0;
    b_cs = 0; b_we = 0; b_address = 0; b_write_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {25'b0, ram_cs, ram_we, a_ready, b_ready}, 32'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Idle after reset: every output stays 0.
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_ctl", {25'b0, ram_cs, ram_we, a_ready, b_ready}, 32'h0);
      check("idle_data", a_read_data | b_read_data | ram_write_data | {20'b0, ram_address}, 32'h0);
    end

    // Single write then read on A.
    xact(1'b0, 4'hF, 12'h010, 32'hDEADBEEF, 2, 0, rd);
    xact(1'b0, 4'h0, 12'h010, 32'h0, 2, 0, rd);
    check("a_read_deadbeef", rd, 32'hDEADBEEF);

    // Port B at both ends of the address space.
    xact(1'b1, 4'hF, 12'hFFF, 32'h12345678, 2, 0, rd);
    xact(1'b1, 4'hF, 12'h000, 32'h9ABCDEF0, 2, 0, rd);
    xact(1'b1, 4'h0, 12'hFFF, 32'h0, 2, 0, rd);
    check("b_read_fff", rd, 32'h12345678);
    xact(1'b1, 4'h0, 12'h000, 32'h0, 2, 0, rd);
    check("b_read_000", rd, 32'h9ABCDEF0);
    check("a_read_data_held", a_read_data, 32'hDEADBEEF);

    // Both ports requesting continuously; last grant was B.
    served_port.delete();
    served_cyc.delete();
    fork
      for (int i = 0; i < 4; i++) xact(1'b0, 4'h0, pool[i], 32'h0, 0, 0, rd_a);
      for (int i = 0; i < 4; i++) xact(1'b1, 4'h0, pool[3 - i], 32'h0, 0, 0, rd_b);
    join
    check("served_count", 32'(served_port.size()), 32'd8);
    for (int i = 0; i < 8 && i < served_port.size(); i++) begin
`ifdef FPGA_RAM_ARB_RR_EN
      check("grant_order", {31'b0, served_port[i]}, 32'(i % 2));
`else
      check("grant_order", {31'b0, served_port[i]}, (i >= 4) ? 32'h1 : 32'h0);
`endif
      if (i > 0) check("grant_spacing", 32'(served_cyc[i] - served_cyc[i-1]), 32'd3);
    end

    // Make every pool word known, then random traffic from both masters.
    for (int i = 0; i < 8; i++) xact(i[0], 4'hF, pool[i], $urandom, 2, 0, rd);
    fork
      rand_driver(1'b0, 25);
      rand_driver(1'b1, 25);
    join

    // Reset lands in the ACCESS cycle of a B write.
    @(posedge clk); #1;
    b_cs = 1'b1; b_we = 4'hF; b_address = 12'h555; b_write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("mid_ram_cs", {31'b0, ram_cs}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ram_cs", {31'b0, ram_cs}, 32'h0);
    check("rst_ram_we", {28'b0, ram_we}, 32'h0);
    b_cs = 1'b0; b_we = 4'h0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_b_ready", {31'b0, b_ready}, 32'h0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_b_ready", {31'b0, b_ready}, 32'h0);
    end
    check("post_rst_rdata", a_read_data | b_read_data, 32'h0);
    xact(1'b0, 4'h0, 12'h555, 32'h0, 2, 0, rd);
    check("lost_write", {31'b0, rd == 32'hCAFEF00D}, 32'h0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
